uc_arbitro_transmissao: RTL and testbench

UC_ARBITRO_TRANSMISSAO -- requirements
Module: uc_arbitro_transmissao

---
 rtl/uc_arbitro_transmissao.sv | 109 ++++++++++
 tb/tb_uc_arbitro_transmissao.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uc_arbitro_transmissao.sv
// uc_arbitro_transmissao: round-robin arbiter granting the serial transmitter to the menu or game unit
// Ports: clock/reset (async, active-low); req_menu/dado_menu and req_jogo/dado_jogo are request
// pulses with their bytes; tx_fim is the transmitter's done pulse; tx_partida/tx_dado start the
// transmitter; fim_menu/fim_jogo acknowledge the served requester; ocupado, erro_timeout, db_estado report status.
module uc_arbitro_transmissao #(
  parameter int TIMEOUT = 1023
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_menu,
  input  logic [7:0] dado_menu,
  input  logic       req_jogo,
  input  logic [7:0] dado_jogo,
  input  logic       tx_fim,
  output logic       tx_partida,
  output logic [7:0] tx_dado,
  output logic       fim_menu,
  output logic       fim_jogo,
  output logic       ocupado,
  output logic       erro_timeout,
  output logic [2:0] db_estado
);
  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    PARTIDA = 3'd1,
    ESPERA  = 3'd2,
    FIM     = 3'd3,
    ABORTA  = 3'd4
  } estado_t;
  localparam logic [9:0] LIMITE = 10'(TIMEOUT);
  estado_t    estado_q;
  logic       pend_menu_q, pend_jogo_q;
  logic [7:0] cap_menu_q, cap_jogo_q;
  logic       grant_q, last_q;
  logic [9:0] cnt_q;
  logic       partida_q, fim_menu_q, fim_jogo_q, erro_q;
  logic       libera, set_menu, set_jogo;
  logic [9:0] cnt_d;
  // grant_q/last_q: 0 = menu, 1 = jogo
  assign libera   = (estado_q == FIM) || (estado_q == ABORTA);
  // a new request from the winner during its release cycle is accepted (set wins over clear)
  assign set_menu = req_menu && (!pend_menu_q || (libera && !grant_q));
  assign set_jogo = req_jogo && (!pend_jogo_q || (libera && grant_q));
  assign cnt_d    = cnt_q + 10'd1;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q    <= OCIOSO;
      pend_menu_q <= 1'b0;
      pend_jogo_q <= 1'b0;
      cap_menu_q  <= 8'h00;
      cap_jogo_q  <= 8'h00;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      partida_q   <= 1'b0;
      fim_menu_q  <= 1'b0;
      fim_jogo_q  <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      partida_q  <= 1'b0;
      fim_menu_q <= 1'b0;
      fim_jogo_q <= 1'b0;
      if (set_menu) begin
        pend_menu_q <= 1'b1;
        cap_menu_q  <= dado_menu;
      end else if (libera && !grant_q) pend_menu_q <= 1'b0;
      if (set_jogo) begin
        pend_jogo_q <= 1'b1;
        cap_jogo_q  <= dado_jogo;
      end else if (libera && grant_q) pend_jogo_q <= 1'b0;
      case (estado_q)
        OCIOSO:
          if (pend_menu_q || pend_jogo_q) begin
            // on a tie the requester not granted last wins
            grant_q   <= (pend_menu_q && pend_jogo_q) ? !last_q : pend_jogo_q;
            partida_q <= 1'b1;
            estado_q  <= PARTIDA;
          end
        PARTIDA: begin
          cnt_q    <= '0;
          estado_q <= ESPERA;
        end
        ESPERA:
          if (tx_fim) begin
            estado_q   <= FIM;
            fim_menu_q <= !grant_q;
            fim_jogo_q <= grant_q;
          end else if (cnt_d == LIMITE) begin
            estado_q   <= ABORTA;
            fim_menu_q <= !grant_q;
            fim_jogo_q <= grant_q;
            erro_q     <= 1'b1;
          end else cnt_q <= cnt_d;
        FIM, ABORTA: begin
          last_q   <= grant_q;
          estado_q <= OCIOSO;
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end
  assign tx_partida   = partida_q;
  assign fim_menu     = fim_menu_q;
  assign fim_jogo     = fim_jogo_q;
  assign erro_timeout = erro_q;
  assign ocupado      = estado_q != OCIOSO;
  assign db_estado    = estado_q;
  assign tx_dado      = (estado_q == OCIOSO) ? 8'h00 : (grant_q ? cap_jogo_q : cap_menu_q);
endmodule

// File: tb/tb_uc_arbitro_transmissao.sv
// tb_uc_arbitro_transmissao: directed self-checking bench for the transmission arbiter
module tb_uc_arbitro_transmissao;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       req_menu = 1'b0, req_jogo = 1'b0, tx_fim = 1'b0;
  logic [7:0] dado_menu = 8'h00, dado_jogo = 8'h00;
  logic       tx_partida, fim_menu, fim_jogo, ocupado, erro_timeout;
  logic [7:0] tx_dado;
  logic [2:0] db_estado;
  int n_chk = 0, n_err = 0;
  int n_part = 0, n_fm = 0, n_fj = 0;
  int p0, fm0, fj0;
  uc_arbitro_transmissao #(.TIMEOUT(15)) dut (
    .clock(clock), .reset(reset),
    .req_menu(req_menu), .dado_menu(dado_menu),
    .req_jogo(req_jogo), .dado_jogo(dado_jogo),
    .tx_fim(tx_fim), .tx_partida(tx_partida), .tx_dado(tx_dado),
    .fim_menu(fim_menu), .fim_jogo(fim_jogo), .ocupado(ocupado),
    .erro_timeout(erro_timeout), .db_estado(db_estado)
  );
  always #5 clock = ~clock;
  always @(negedge clock) begin
    if (tx_partida) n_part++;
    if (fim_menu) n_fm++;
    if (fim_jogo) n_fj++;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_estado"}, db_estado, 0);
    check({tag, "_ocupado"}, ocupado, 0);
    check({tag, "_dado"}, tx_dado, 8'h00);
    check({tag, "_partida"}, tx_partida, 0);
    check({tag, "_fims"}, {fim_menu, fim_jogo}, 2'b00);
  endtask
  task automatic wait_partida();
    int n = 0;
    while (!tx_partida && n < 50) begin
      tick();
      n++;
    end
    check("partida_bound", n < 50, 1);
  endtask
  // serve one transaction: tx_fim is sampled 'espera' cycles into ESPERA
  task automatic serve(input logic [7:0] d, input logic menu, input int espera);
    wait_partida();
    check("dado_partida", tx_dado, d);
    check("ocupado", ocupado, 1);
    repeat (espera) tick();
    check("espera", db_estado, 2);
    tx_fim = 1'b1;
    tick();
    tx_fim = 1'b0;
    check("estado_fim", db_estado, 3);
    check("fim_menu", fim_menu, menu);
    check("fim_jogo", fim_jogo, !menu);
    check("dado_fim", tx_dado, d);
    tick();
    check("volta_ocioso", db_estado, 0);
  endtask
  initial begin
    tick();
    check_idle("rst");
    check("rst_erro", erro_timeout, 0);
    reset = 1'b1;
    tick();
    // single menu request with latency check
    req_menu = 1'b1; dado_menu = 8'hF4;
    tick();
    req_menu = 1'b0;
    p0 = n_part; fm0 = n_fm; fj0 = n_fj;
    check("lat_ocioso", db_estado, 0);
    tick();
    check("lat_partida", tx_partida, 1);
    check("lat_estado", db_estado, 1);
    serve(8'hF4, 1'b1, 5);
    tick();
    check("unico_partida", n_part, p0 + 1);
    check("unico_fim_menu", n_fm, fm0 + 1);
    check("sem_fim_jogo", n_fj, fj0);
    check_idle("apos_unico");
    // ties alternate: menu, jogo, then menu again
    do_reset();
    req_menu = 1'b1; dado_menu = 8'hF0;
    req_jogo = 1'b1; dado_jogo = 8'hA5;
    tick();
    req_menu = 1'b0; req_jogo = 1'b0;
    serve(8'hF0, 1'b1, 3);
    serve(8'hA5, 1'b0, 2);
    req_menu = 1'b1; dado_menu = 8'hF3;
    req_jogo = 1'b1; dado_jogo = 8'h5A;
    tick();
    req_menu = 1'b0; req_jogo = 1'b0;
    serve(8'hF3, 1'b1, 2);
    serve(8'h5A, 1'b0, 4);
    // duplicate request is ignored
    p0 = n_part;
    req_menu = 1'b1; dado_menu = 8'hF1;
    tick();
    dado_menu = 8'hF2;
    tick();
    req_menu = 1'b0;
    serve(8'hF1, 1'b1, 2);
    repeat (5) tick();
    check("dup_partidas", n_part, p0 + 1);
    check_idle("dup");
    // request from the winner during FIM is accepted with new data
    req_menu = 1'b1; dado_menu = 8'h11;
    tick();
    req_menu = 1'b0;
    wait_partida();
    repeat (2) tick();
    tx_fim = 1'b1;
    tick();
    tx_fim = 1'b0;
    check("fim_set_estado", db_estado, 3);
    req_menu = 1'b1; dado_menu = 8'h22;
    tick();
    req_menu = 1'b0;
    serve(8'h22, 1'b1, 2);
    // timeout abort after 15 ESPERA cycles
    req_jogo = 1'b1; dado_jogo = 8'h3C;
    tick();
    req_jogo = 1'b0;
    wait_partida();
    repeat (15) tick();
    check("to_ainda_espera", db_estado, 2);
    check("to_erro_antes", erro_timeout, 0);
    tick();
    check("to_aborta", db_estado, 4);
    check("to_fim_jogo", fim_jogo, 1);
    check("to_fim_menu", fim_menu, 0);
    check("to_dado", tx_dado, 8'h3C);
    check("to_erro", erro_timeout, 1);
    tick();
    check("to_ocioso", db_estado, 0);
    req_menu = 1'b1; dado_menu = 8'hF2;
    tick();
    req_menu = 1'b0;
    serve(8'hF2, 1'b1, 1);
    check("to_erro_sticky", erro_timeout, 1);
    // stray tx_fim while idle
    fm0 = n_fm; fj0 = n_fj;
    tx_fim = 1'b1;
    tick();
    tx_fim = 1'b0;
    check("stray_estado", db_estado, 0);
    tick();
    check("stray_fims", n_fm + n_fj, fm0 + fj0);
    check("stray_estado2", db_estado, 0);
    // reset during ESPERA abandons the transaction
    req_jogo = 1'b1; dado_jogo = 8'h77;
    tick();
    req_jogo = 1'b0;
    wait_partida();
    repeat (3) tick();
    check("mid_espera", db_estado, 2);
    #2 reset = 1'b0;
    #1;
    check_idle("mid_rst");
    check("mid_rst_erro", erro_timeout, 0);
    tick();
    reset = 1'b1;
    p0 = n_part; fm0 = n_fm; fj0 = n_fj;
    tx_fim = 1'b1;
    tick();
    tx_fim = 1'b0;
    repeat (4) tick();
    check("mid_sem_fim", n_fm + n_fj, fm0 + fj0);
    check("mid_sem_partida", n_part, p0);
    check_idle("mid_final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
